// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared states, bus constants and address helper for the I2C target
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    // Level seen on SDA during the acknowledge slot
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Address byte carries the 7-bit address in [7:1] and R/W in [0]
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own);
        return addr_byte[7:1] == own;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - synchronizer and rise/fall detector for one bus line
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic Clock,
    input  logic Clear,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw line through the synchronizer and remember the previous synced value;
    // everything resets high, matching an idle (released) bus
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with one address, byte write sink and byte read source
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_rx
);

    logic       scl, scl_rise, scl_fall;
    logic       sda, sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic       last_bit;
    logic [7:0] byte_in;

    i2c_state_t state_q, state_d;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic       rw_q;
    logic       tx_load;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .Clock (Clock),
        .Clear (Clear),
        .din   (scl_in),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .Clock (Clock),
        .Clear (Clear),
        .din   (sda_in),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign last_bit  = (bit_cnt == 3'd7);
    assign byte_in   = {shift_q[6:0], sda};

    // State register
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: bus conditions override everything; in the ACK slots sda_oe marks
    // whether the first falling edge (start of our ACK) has already happened
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && last_bit) begin
                        state_d = addr_match(byte_in, ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall && sda_oe) begin
                        state_d = rw_q ? ST_RD_DATA : ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise && last_bit) begin
                        state_d = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall && sda_oe) begin
                        state_d = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise && last_bit) begin
                        state_d = ST_RD_ACK;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        state_d = (sda == ACK) ? ST_RD_DATA : ST_IGNORE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath: bit counter, shift register, SDA drive and the one-cycle status pulses
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            nack_rx  <= 1'b0;
            bit_cnt  <= 3'd0;
            shift_q  <= 8'h00;
            rw_q     <= 1'b0;
            tx_load  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            nack_rx  <= 1'b0;
            tx_load  <= tx_req;
            if (stop_det) begin
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (start_det) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                rw_q <= sda;
                                if (addr_match(byte_in, ADDR)) begin
                                    busy   <= 1'b1;
                                    tx_req <= sda;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (state_q == ST_ADDR_ACK && rw_q) begin
                                // End of address ACK on a read also launches data bit 7
                                sda_oe <= ~shift_q[7];
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift_q <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                rx_data  <= byte_in;
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            sda_oe <= ~shift_q[7];
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                        end
                        if (scl_rise) begin
                            tx_req  <= (sda == ACK);
                            nack_rx <= (sda == NACK);
                        end
                    end
                    default: begin
                    end
                endcase
            end
            // Next read byte arrives two cycles after tx_req; bus edges are far apart
            if (tx_load) begin
                shift_q <= tx_data;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized self-checking bench for i2c_target
module tb_i2c_target;

    localparam logic [6:0] ADDR_P = 7'h42;
    localparam int         Q      = 5;

    logic       Clock = 1'b0;
    logic       Clear = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;
    logic       nack_rx;

    int n_cmp = 0;
    int n_err = 0;
    int n_rxv = 0, n_txr = 0, n_nack = 0, n_oe = 0, n_busy = 0;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target #(.ADDR(ADDR_P), .SYNC_STAGES(2)) dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .scl_in   (scl_drv),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .nack_rx  (nack_rx)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (rx_valid) n_rxv++;
        if (tx_req)   n_txr++;
        if (nack_rx)  n_nack++;
        if (sda_oe)   n_oe++;
        if (busy)     n_busy++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rule: the target acknowledges only its own 7-bit address
    function automatic logic model_ack(input logic [7:0] a);
        return (a[7:1] == ADDR_P) ? 1'b0 : 1'b1;
    endfunction

    task automatic wait_q();
        repeat (Q) @(posedge Clock);
        #1;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_drv = b;    wait_q();
        scl_drv = 1'b1; wait_q();
        r = sda_bus;    wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic xfer_byte(input logic [7:0] o, output logic [7:0] i);
        logic rb;
        for (int k = 7; k >= 0; k--) begin
            bit_xfer(o[k], rb);
            i[k] = rb;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clock);
        #1;
        n_cmp++; if (sda_oe !== 1'b0)   begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_cmp++; if ({rx_valid, tx_req, nack_rx} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {rx_valid, tx_req, nack_rx}); end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        Clear = 1'b1;
        wait_q();
        n_cmp++; if ({sda_oe, busy, rx_valid} !== 3'b000) begin n_err++; $display("FAIL post_reset_idle: got %b want 000", {sda_oe, busy, rx_valid}); end
    endtask

    task automatic test_write();
        logic [7:0] d [4];
        logic [7:0] junk;
        logic       a;
        int         s_rxv;
        d[0] = 8'hA5;
        for (int i = 1; i < 4; i++) d[i] = 8'($urandom);
        s_rxv = n_rxv;
        bus_start();
        xfer_byte(8'h84, junk);
        bit_xfer(1'b1, a);
        n_cmp++; if (a !== model_ack(8'h84)) begin n_err++; $display("FAIL wr_addr_ack: got %b want %b", a, model_ack(8'h84)); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            xfer_byte(d[i], junk);
            bit_xfer(1'b1, a);
            n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL wr_data_ack[%0d]: got %b want 0", i, a); end
            n_cmp++; if (rx_data !== d[i]) begin n_err++; $display("FAIL wr_rx_data[%0d]: got %h want %h", i, rx_data, d[i]); end
            n_cmp++; if (n_rxv - s_rxv !== i + 1) begin n_err++; $display("FAIL wr_rx_valid_count[%0d]: got %0d want %0d", i, n_rxv - s_rxv, i + 1); end
        end
        bus_stop();
        wait_q();
        n_cmp++; if ({busy, sda_oe} !== 2'b00) begin n_err++; $display("FAIL wr_after_stop: got %b want 00", {busy, sda_oe}); end
    endtask

    task automatic test_wrong_addr();
        logic [7:0] addrs [4];
        logic [7:0] junk;
        logic       a;
        int         s_oe, s_busy, s_rxv;
        addrs[0] = 8'h86;
        addrs[1] = 8'h00;
        for (int i = 2; i < 4; i++) begin
            addrs[i] = 8'($urandom);
            while (addrs[i][7:1] == ADDR_P) addrs[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            s_oe = n_oe; s_busy = n_busy; s_rxv = n_rxv;
            bus_start();
            xfer_byte(addrs[i], junk);
            bit_xfer(1'b1, a);
            n_cmp++; if (a !== model_ack(addrs[i])) begin n_err++; $display("FAIL nomatch_ack[%h]: got %b want %b", addrs[i], a, model_ack(addrs[i])); end
            xfer_byte(8'($urandom), junk);
            bit_xfer(1'b1, a);
            bus_stop();
            n_cmp++; if ({n_oe - s_oe, n_busy - s_busy, n_rxv - s_rxv} !== {32'd0, 32'd0, 32'd0}) begin
                n_err++; $display("FAIL nomatch_quiet[%h]: oe=%0d busy=%0d rxv=%0d want all 0", addrs[i], n_oe - s_oe, n_busy - s_busy, n_rxv - s_rxv);
            end
        end
    endtask

    task automatic test_read(input logic [7:0] t0, input logic [7:0] t1);
        logic [7:0] got, junk;
        logic       a;
        int         s_txr, s_nack;
        s_txr = n_txr; s_nack = n_nack;
        tx_data = t0;
        bus_start();
        xfer_byte(8'h85, junk);
        bit_xfer(1'b1, a);
        n_cmp++; if (a !== model_ack(8'h85)) begin n_err++; $display("FAIL rd_addr_ack: got %b want %b", a, model_ack(8'h85)); end
        xfer_byte(8'hFF, got);
        n_cmp++; if (got !== t0) begin n_err++; $display("FAIL rd_byte0: got %h want %h", got, t0); end
        tx_data = t1;
        bit_xfer(1'b0, a);
        xfer_byte(8'hFF, got);
        n_cmp++; if (got !== t1) begin n_err++; $display("FAIL rd_byte1: got %h want %h", got, t1); end
        bit_xfer(1'b1, a);
        n_cmp++; if (n_txr - s_txr !== 2) begin n_err++; $display("FAIL rd_tx_req_count: got %0d want 2", n_txr - s_txr); end
        n_cmp++; if (n_nack - s_nack !== 1) begin n_err++; $display("FAIL rd_nack_count: got %0d want 1", n_nack - s_nack); end
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_release_after_nack: got %b want 0", sda_oe); end
        bus_stop();
        wait_q();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_rep_start();
        logic [7:0] junk, got, t;
        logic       a, r;
        int         s_rxv;
        t = 8'($urandom);
        tx_data = t;
        s_rxv = n_rxv;
        bus_start();
        xfer_byte(8'h84, junk);
        bit_xfer(1'b1, a);
        for (int k = 0; k < 4; k++) bit_xfer(1'($urandom), r);
        bus_start();
        xfer_byte(8'h85, junk);
        bit_xfer(1'b1, a);
        n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL rs_addr_ack: got %b want 0", a); end
        xfer_byte(8'hFF, got);
        n_cmp++; if (got !== t) begin n_err++; $display("FAIL rs_read: got %h want %h", got, t); end
        bit_xfer(1'b1, a);
        bus_stop();
        n_cmp++; if (n_rxv - s_rxv !== 0) begin n_err++; $display("FAIL rs_no_rx_valid: got %0d want 0", n_rxv - s_rxv); end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] junk, d;
        logic       a;
        int         s_oe, s_busy, s_rxv;
        bus_start();
        xfer_byte(8'h84, junk);
        n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rst_ack_driving: got %b want 1", sda_oe); end
        #2 Clear = 1'b0;
        #1;
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_async_sda_oe: got %b want 0", sda_oe); end
        n_cmp++; if ({busy, rx_valid, tx_req, nack_rx, rx_data} !== 12'h000) begin
            n_err++; $display("FAIL rst_outputs: got %h want 000", {busy, rx_valid, tx_req, nack_rx, rx_data});
        end
        repeat (2) @(posedge Clock);
        #1 Clear = 1'b1;
        s_oe = n_oe; s_busy = n_busy; s_rxv = n_rxv;
        bit_xfer(1'b1, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL rst_no_ack: got %b want 1", a); end
        xfer_byte(8'($urandom), junk);
        bit_xfer(1'b1, a);
        bus_stop();
        n_cmp++; if ({n_oe - s_oe, n_busy - s_busy, n_rxv - s_rxv} !== {32'd0, 32'd0, 32'd0}) begin
            n_err++; $display("FAIL rst_ignores_bus: oe=%0d busy=%0d rxv=%0d want all 0", n_oe - s_oe, n_busy - s_busy, n_rxv - s_rxv);
        end
        d = 8'($urandom);
        bus_start();
        xfer_byte(8'h84, junk);
        bit_xfer(1'b1, a);
        xfer_byte(d, junk);
        bit_xfer(1'b1, a);
        n_cmp++; if ({a, rx_data} !== {1'b0, d}) begin n_err++; $display("FAIL rst_recover: got %b/%h want 0/%h", a, rx_data, d); end
        bus_stop();
    endtask

    task automatic test_stop_mid_read();
        logic [7:0] junk;
        logic [3:0] got;
        logic       a, r;
        int         cyc, s_oe, s_txr;
        tx_data = 8'h5A;
        bus_start();
        xfer_byte(8'h85, junk);
        bit_xfer(1'b1, a);
        for (int k = 3; k >= 0; k--) begin
            bit_xfer(1'b1, r);
            got[k] = r;
        end
        n_cmp++; if (got !== 4'h5) begin n_err++; $display("FAIL sm_partial: got %h want 5", got); end
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 10) begin
            @(posedge Clock); #1;
            cyc++;
        end
        n_cmp++; if (cyc >= 10) begin n_err++; $display("FAIL sm_busy_timeout: busy=%b after %0d cycles want 0", busy, cyc); end
        @(posedge Clock); #1;
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL sm_sda_oe: got %b want 0", sda_oe); end
        s_oe = n_oe; s_txr = n_txr;
        wait_q();
        scl_drv = 1'b0; wait_q();
        for (int k = 0; k < 9; k++) bit_xfer(1'b1, r);
        n_cmp++; if ({n_oe - s_oe, n_txr - s_txr, 31'd0, busy} !== {32'd0, 32'd0, 32'd0}) begin
            n_err++; $display("FAIL sm_idle_after_stop: oe=%0d txr=%0d busy=%b want 0", n_oe - s_oe, n_txr - s_txr, busy);
        end
        scl_drv = 1'b1; wait_q();
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read(8'h3C, 8'hF0);
        test_read(8'($urandom), 8'($urandom));
        test_rep_start();
        test_reset_mid_ack();
        test_stop_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h42, is the 7-bit target address the block answers to.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth for scl_in and sda_in.
REQ-003 Clock  input  1  system clock; at least 8x the SCL frequency.
REQ-004 Clear  input  1  asynchronous, active-low reset.
REQ-005 scl_in  input  1  raw bus SCL.
REQ-006 sda_in  input  1  raw bus SDA.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 rx_data  output  8  last byte written by the controller.
REQ-009 rx_valid  output  1  one-Clock pulse when rx_data is updated.
REQ-010 tx_data  input  8  byte to return on a read; sampled when tx_req pulses.
REQ-011 tx_req  output  1  one-Clock pulse requesting the next read byte.
REQ-012 busy  output  1  high from an address match until STOP.
REQ-013 nack_rx  output  1  one-Clock pulse when the controller NACKs a read byte.

Function
REQ-014 scl_in and sda_in SHALL pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized values only.
REQ-015 START (sync SDA falls while sync SCL high) SHALL enter ADDR from any state, including repeated START mid-byte.
REQ-016 STOP (sync SDA rises while sync SCL high) SHALL enter IDLE from any state, clear busy and drop sda_oe on the next Clock.
REQ-017 FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-018 Data bits SHALL be sampled on the sync SCL rising edge, MSB first; a 3-bit counter SHALL count 0..7 and wrap to 0 at each ACK slot.
REQ-019 ADDR: after 8 bits, if bits[7:1]==ADDR, go to ADDR_ACK and assert busy; otherwise go to IGNORE with sda_oe held 0.
REQ-020 IGNORE SHALL leave the bus untouched until START or STOP.
REQ-021 ADDR_ACK: sda_oe SHALL go to 1 on the SCL falling edge after bit 0 and return to 0 on the following SCL falling edge.
REQ-022 R/W=0: after ADDR_ACK go to WR_DATA; on the 8th rising edge load rx_data and pulse rx_valid on the next Clock; then WR_ACK drives ACK as in REQ-021 and returns to WR_DATA.
REQ-023 R/W=1: tx_req SHALL pulse in the Clock after the address match; tx_data SHALL be latched into the shift register 2 Clocks later.
REQ-024 RD_DATA: each bit SHALL be driven on the SCL falling edge (sda_oe = ~bit), starting with the falling edge that ends the ACK slot.
REQ-025 RD_ACK: sda_oe=0; if sampled SDA=0 (ACK), pulse tx_req and go to RD_DATA; if SDA=1 (NACK), pulse nack_rx and go to IGNORE.
REQ-026 A START or STOP that ends a byte early SHALL NOT pulse rx_valid.
REQ-027 The general-call address 7'h00 SHALL NOT match unless ADDR==7'h00.

Reset
REQ-028 On Clear=0: state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, nack_rx=0, counter=0, synchronizers=1.
REQ-029 Reset release mid-transfer SHALL stay in IDLE until the next START.

Structure
REQ-030 A shared package i2c_pkg SHALL hold the state enum and the constants ACK=1'b0 and NACK=1'b1.
REQ-031 A sub-module i2c_sync_edge SHALL hold the synchronizer and the rise/fall detectors for one line; it SHALL be instantiated twice.

Verification
REQ-032 Write 0x84 (address 0x42, write), data 0xA5, STOP -> ACK on both slots, rx_data=0xA5, one rx_valid pulse, busy low after STOP.
REQ-033 Address 0x43 write -> sda_oe never asserted, busy stays 0, no rx_valid.
REQ-034 Read 0x85 with tx_data=0x3C, then 0xF0; controller ACKs the first byte and NACKs the second -> SDA carries 0x3C then 0xF0, two tx_req pulses, one nack_rx.
REQ-035 Write 0x84, send 4 bits of data, then repeated START and 0x85 -> no rx_valid, read proceeds with ACK.
REQ-036 Clear=0 while sda_oe=1 during an ACK -> sda_oe=0 asynchronously, all outputs at their reset values, block ignores the bus until the next START.
REQ-037 STOP issued mid-read byte -> sda_oe=0 within 1 Clock after STOP is detected, state IDLE.
